// File: rtl/wallace_cpa_stage_pkg.sv
// Shared width constants for the Booth/Wallace 16x16 multiplier final adder stage.
package wallace_cpa_stage_pkg;

    localparam int MULT_W    = 16;
    localparam int MULT_PW   = 2 * MULT_W;
    localparam int ACC_W_DEF = 40;

endpackage

// File: rtl/wallace_cpa_stage_add.sv
// cpa_add_slice: W-bit binary adder with carry in/out, one per product half.
module cpa_add_slice
    import wallace_cpa_stage_pkg::*;
#(
    parameter int W = MULT_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/wallace_cpa_stage.sv
// Two-stage carry-propagate adder closing the Wallace tree, with valid/ready flow control.
// Optional running accumulator on the output handshake when CPA_ACC_EN is defined.
module wallace_cpa_stage
    import wallace_cpa_stage_pkg::*;
#(
    parameter int W     = MULT_W,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [2*W-1:0] sum_vec,
    input  logic [2*W-1:0] carry_vec,
    output logic           m_valid,
    input  logic           m_ready,
`ifdef CPA_ACC_EN
    output logic [2*W-1:0] product,
    input  logic                    acc_clr,
    output logic signed [ACC_W-1:0] acc_out
`else
    output logic [2*W-1:0] product
`endif
);

    logic           vld_p1;
    logic           vld_p2;
    logic           accept;
    logic           ld2;
    logic [W-1:0]   lo_p1;
    logic           c_lo_p1;
    logic [W-1:0]   sum_hi_p1;
    logic [W-1:0]   carry_hi_p1;
    logic [W-1:0]   lo_nxt;
    logic           c_lo_nxt;
    logic [W-1:0]   hi_nxt;
    logic           co_unused;

    // ld2 only looks at m_ready and stage state, so s_ready never depends on s_valid.
    assign ld2     = vld_p1 & (~vld_p2 | m_ready);
    assign s_ready = ~vld_p1 | ld2;
    assign accept  = s_valid & s_ready;
    assign m_valid = vld_p2;

    cpa_add_slice #(.W(W)) u_add_lo (
        .a  (sum_vec[W-1:0]),
        .b  (carry_vec[W-1:0]),
        .ci (1'b0),
        .s  (lo_nxt),
        .co (c_lo_nxt)
    );

    // Carry out of the top bit is dropped: product wraps modulo 2^(2W).
    cpa_add_slice #(.W(W)) u_add_hi (
        .a  (sum_hi_p1),
        .b  (carry_hi_p1),
        .ci (c_lo_p1),
        .s  (hi_nxt),
        .co (co_unused)
    );

    // Stage 1: low-half add, upper halves parked for stage 2
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_p1      <= 1'b0;
            lo_p1       <= '0;
            c_lo_p1     <= 1'b0;
            sum_hi_p1   <= '0;
            carry_hi_p1 <= '0;
        end else begin
            if (accept) begin
                vld_p1      <= 1'b1;
                lo_p1       <= lo_nxt;
                c_lo_p1     <= c_lo_nxt;
                sum_hi_p1   <= sum_vec[2*W-1:W];
                carry_hi_p1 <= carry_vec[2*W-1:W];
            end else if (ld2) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    // Stage 2: high-half add with the propagated carry, output register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_p2  <= 1'b0;
            product <= '0;
        end else begin
            if (ld2) begin
                vld_p2  <= 1'b1;
                product <= {hi_nxt, lo_p1};
            end else if (vld_p2 && m_ready) begin
                vld_p2 <= 1'b0;
            end
        end
    end

`ifdef CPA_ACC_EN
    logic                    clr_p1;
    logic                    clr_p2;
    logic signed [2*W-1:0]   prod_s;

    assign prod_s = product;

    // acc_clr rides with its beat so it applies to the matching product
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clr_p1  <= 1'b0;
            clr_p2  <= 1'b0;
            acc_out <= '0;
        end else begin
            if (accept) begin
                clr_p1 <= acc_clr;
            end
            if (ld2) begin
                clr_p2 <= clr_p1;
            end
            if (vld_p2 && m_ready) begin
                acc_out <= clr_p2 ? ACC_W'(prod_s) : acc_out + ACC_W'(prod_s);
            end
        end
    end

    if (ACC_W < 2*W) begin : g_acc_w_chk
        $error("ACC_W must be at least 2*W");
    end
`else
    // Accumulator absent; ACC_W is still validated so both builds accept the same parameters.
    if (ACC_W < 2*W) begin : g_acc_w_chk
        $error("ACC_W must be at least 2*W");
    end
`endif

endmodule

// File: tb/tb_wallace_cpa_stage.sv
// Directed and random-stream bench for wallace_cpa_stage; accumulator checks when CPA_ACC_EN is defined.
module tb_wallace_cpa_stage;

    localparam int W     = 16;
    localparam int ACC_W = 40;

    logic           sys_clk;
    logic           sys_rst_n;
    logic           s_valid;
    logic           s_ready;
    logic [2*W-1:0] sum_vec;
    logic [2*W-1:0] carry_vec;
    logic           m_valid;
    logic           m_ready;
    logic [2*W-1:0] product;
`ifdef CPA_ACC_EN
    logic                    acc_clr;
    logic signed [ACC_W-1:0] acc_out;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    wallace_cpa_stage #(.W(W), .ACC_W(ACC_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .sum_vec   (sum_vec),
        .carry_vec (carry_vec),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
`ifdef CPA_ACC_EN
        .product   (product),
        .acc_clr   (acc_clr),
        .acc_out   (acc_out)
`else
        .product   (product)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // One beat through an otherwise idle pipe with m_ready held high.
    task automatic send_one(input string tag, input logic [31:0] s, input logic [31:0] c,
                            input logic [31:0] exp);
        m_ready   = 1'b1;
        s_valid   = 1'b1;
        sum_vec   = s;
        carry_vec = c;
        chk({tag, "_s_ready"}, 64'(s_ready), 64'd1);
        step();
        s_valid = 1'b0;
        chk({tag, "_lat1_m_valid"}, 64'(m_valid), 64'd0);
        step();
        chk({tag, "_m_valid"}, 64'(m_valid), 64'd1);
        chk({tag, "_product"}, 64'(product), 64'(exp));
        step();
        chk({tag, "_drained"}, 64'(m_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] exp_v;
        int sent, rcvd, cyc;

        sys_rst_n = 1'b0;
        s_valid   = 1'b0;
        m_ready   = 1'b0;
        sum_vec   = '0;
        carry_vec = '0;
`ifdef CPA_ACC_EN
        acc_clr   = 1'b0;
`endif
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
`ifdef CPA_ACC_EN
        chk("rst_acc_out", 64'(acc_out), 64'd0);
`endif
        sys_rst_n = 1'b1;
        step();
        chk("post_rst_m_valid", 64'(m_valid), 64'd0);

        send_one("cross_carry", 32'h0000FFFF, 32'h00000001, 32'h00010000);
        send_one("wrap_zero",   32'hFFFFFFFF, 32'h00000001, 32'h00000000);
        send_one("neg_11",      32'hFFFFFFF0, 32'h00000005, 32'hFFFFFFF5);
        send_one("hi_only",     32'h12340000, 32'h11110000, 32'h23450000);

        // Backpressure: A,B fill both stages, C waits
        m_ready   = 1'b0;
        s_valid   = 1'b1;
        sum_vec   = 32'h00000010; carry_vec = 32'h00000001;  // A = 0x11
        step();
        chk("bp_ready_after_A", 64'(s_ready), 64'd1);
        sum_vec   = 32'h00000020; carry_vec = 32'h00000002;  // B = 0x22
        step();
        sum_vec   = 32'h00000030; carry_vec = 32'h00000003;  // C = 0x33
        chk("bp_full_s_ready", 64'(s_ready), 64'd0);
        step();
        chk("bp_hold_s_ready", 64'(s_ready), 64'd0);
        chk("bp_hold_m_valid", 64'(m_valid), 64'd1);
        chk("bp_hold_product", 64'(product), 64'h11);
        m_ready = 1'b1;
        #1;
        chk("bp_release_s_ready", 64'(s_ready), 64'd1);
        step();
        s_valid = 1'b0;
        chk("bp_out_B", 64'(product), 64'h22);
        chk("bp_out_B_valid", 64'(m_valid), 64'd1);
        step();
        chk("bp_out_C", 64'(product), 64'h33);
        chk("bp_out_C_valid", 64'(m_valid), 64'd1);
        step();
        chk("bp_empty", 64'(m_valid), 64'd0);

        // Random stream against a reference queue
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 1000 && cyc < 20000) begin
            s_valid   = (sent < 1000) && ($urandom_range(0, 3) != 0);
            sum_vec   = $urandom;
            carry_vec = $urandom;
            m_ready   = ($urandom_range(0, 3) != 0);
            #1;
            if (s_valid && s_ready) begin
                exp_v = sum_vec + carry_vec;
                q.push_back(exp_v);
                sent++;
            end
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    chk("rand_spurious", 64'(m_valid), 64'd0);
                end else begin
                    exp_v = q.pop_front();
                    chk("rand_beat", 64'(product), 64'(exp_v));
                end
                rcvd++;
            end
            @(posedge sys_clk);
            #1;
            cyc++;
        end
        chk("rand_count", 64'(rcvd), 64'd1000);
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        chk("rand_empty", 64'(m_valid), 64'd0);

        // Reset mid-operation with two beats in flight
        m_ready   = 1'b0;
        s_valid   = 1'b1;
        sum_vec   = 32'h0000AAAA; carry_vec = 32'h00000001;
        step();
        step();
        s_valid = 1'b0;
        chk("midrst_full", 64'(m_valid), 64'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_async_m_valid", 64'(m_valid), 64'd0);
        step();
        sys_rst_n = 1'b1;
        m_ready   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_no_stale", 64'(m_valid), 64'd0);
        end

`ifdef CPA_ACC_EN
        acc_clr = 1'b1;
        send_one("acc_first", 32'h00000005, 32'h00000000, 32'h00000005);
        chk("acc_after_5", 64'(acc_out), 64'd5);
        acc_clr = 1'b0;
        send_one("acc_second", 32'hFFFFFFFD, 32'h00000000, 32'hFFFFFFFD);
        chk("acc_after_m3", 64'(acc_out), 64'd2);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
